// File: rtl/decoder_pkg.sv
// decoder_pkg: opcode constants, register codes, FSM states and opcode classes
// shared by the 8085 instruction decoder and the blocks that reuse its classification.
package decoder_pkg;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] OP_JMP   = 8'hC3;
    localparam logic [7:0] MVI_MASK = 8'hC7;
    localparam logic [7:0] MVI_VAL  = 8'h06;
    localparam logic [7:0] MOV_MASK = 8'hC0;
    localparam logic [7:0] MOV_VAL  = 8'h40;
    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;
    typedef enum logic [2:0] {S_FETCH, S_IMM, S_ADDR_LO, S_ADDR_HI, S_HALT} state_t;
    typedef enum logic [2:0] {C_NOP, C_MVI, C_MOV, C_JMP, C_HLT, C_ILL} op_class_t;
endpackage

// File: rtl/opcode_decoder_if.sv
// opcode_decoder_if: instruction stream handshake plus register-file/PC controls.
// slave is the decoder side, master is the fetch/datapath side.
interface opcode_decoder_if #(parameter int DATA_W = 8);
    logic                  instr_valid;
    logic [DATA_W-1:0]     instr_data;
    logic                  instr_ready;
    logic                  reg_wr_en;
    logic [2:0]            reg_wr_sel;
    logic                  reg_wr_src;
    logic [2:0]            reg_rd_sel;
    logic [DATA_W-1:0]     reg_wr_data;
    logic                  pc_load;
    logic [2*DATA_W-1:0]   branch_address;
    logic                  halted;
    logic                  illegal_op;
    modport slave (
        input  instr_valid, instr_data,
        output instr_ready, reg_wr_en, reg_wr_sel, reg_wr_src, reg_rd_sel,
               reg_wr_data, pc_load, branch_address, halted, illegal_op
    );
    modport master (
        output instr_valid, instr_data,
        input  instr_ready, reg_wr_en, reg_wr_sel, reg_wr_src, reg_rd_sel,
               reg_wr_data, pc_load, branch_address, halted, illegal_op
    );
endinterface

// File: rtl/opcode_classify.sv
// opcode_classify: combinational opcode -> {class, dst, src} lookup.
// HLT is checked first because 0x76 would otherwise look like MOV M,M.
module opcode_classify
    import decoder_pkg::*;
(
    input  logic [7:0] i_op,
    output op_class_t  o_cls,
    output logic [2:0] o_dst,
    output logic [2:0] o_src
);
    assign o_dst = i_op[5:3];
    assign o_src = i_op[2:0];
    always_comb
        o_cls = (i_op == OP_HLT) ? C_HLT :
                (i_op == OP_NOP) ? C_NOP :
                (i_op == OP_JMP) ? C_JMP :
                ((i_op & MVI_MASK) == MVI_VAL && o_dst != REG_M) ? C_MVI :
                ((i_op & MOV_MASK) == MOV_VAL && o_dst != REG_M && o_src != REG_M) ? C_MOV :
                C_ILL;
endmodule

// File: rtl/opcode_decoder.sv
// opcode_decoder: 8085 instruction decoder FSM driving register-file writes and PC loads.
// All control outputs are registered, so each strobe appears one cycle after the final accept.
module opcode_decoder
    import decoder_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input logic              clk,
    input logic              reset,
    opcode_decoder_if.slave  bus
);
    localparam int ADDR_W = 2 * DATA_W;
    state_t            r_state, w_next;
    op_class_t         w_cls;
    logic [2:0]        w_op_dst, w_op_src;
    logic              w_acc;
    logic              r_wr_en, w_wr_en, r_wr_src, w_wr_src;
    logic              r_pc_load, w_pc_load, r_ill, w_ill;
    logic [2:0]        r_wr_sel, w_wr_sel, r_rd_sel, w_rd_sel, r_dst, w_dst;
    logic [DATA_W-1:0] r_wr_data, w_wr_data, r_lo, w_lo;
    logic [ADDR_W-1:0] r_addr, w_addr;

    opcode_classify u_classify (
        .i_op  (bus.instr_data[7:0]),
        .o_cls (w_cls),
        .o_dst (w_op_dst),
        .o_src (w_op_src)
    );

    // Gating with reset keeps ready low while the decoder is held in reset.
    assign bus.instr_ready    = reset && (r_state != S_HALT);
    assign w_acc              = bus.instr_valid && bus.instr_ready;
    assign bus.halted         = (r_state == S_HALT);
    assign bus.reg_wr_en      = r_wr_en;
    assign bus.reg_wr_src     = r_wr_src;
    assign bus.reg_wr_sel     = r_wr_sel;
    assign bus.reg_rd_sel     = r_rd_sel;
    assign bus.reg_wr_data    = r_wr_data;
    assign bus.pc_load        = r_pc_load;
    assign bus.branch_address = r_addr;
    assign bus.illegal_op     = r_ill;

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_pc_load = 1'b0;
        w_ill     = 1'b0;
        w_wr_src  = r_wr_src;
        w_wr_sel  = r_wr_sel;
        w_rd_sel  = r_rd_sel;
        w_wr_data = r_wr_data;
        w_addr    = r_addr;
        w_lo      = r_lo;
        w_dst     = r_dst;
        if (w_acc)
            case (r_state)
                S_FETCH:
                    case (w_cls)
                        C_MVI: begin
                            w_dst  = w_op_dst;
                            w_next = S_IMM;
                        end
                        C_MOV: begin
                            w_wr_en  = 1'b1;
                            w_wr_src = 1'b1;
                            w_wr_sel = w_op_dst;
                            w_rd_sel = w_op_src;
                        end
                        C_JMP: w_next = S_ADDR_LO;
                        C_HLT: w_next = S_HALT;
                        C_ILL: begin
                            w_ill  = 1'b1;
                            w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                        end
                        default: ;
                    endcase
                S_IMM: begin
                    w_wr_en   = 1'b1;
                    w_wr_src  = 1'b0;
                    w_wr_sel  = r_dst;
                    w_wr_data = bus.instr_data;
                    w_next    = S_FETCH;
                end
                S_ADDR_LO: begin
                    w_lo   = bus.instr_data;
                    w_next = S_ADDR_HI;
                end
                S_ADDR_HI: begin
                    w_addr    = {bus.instr_data, r_lo};
                    w_pc_load = 1'b1;
                    w_next    = S_FETCH;
                end
                default: ;
            endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state   <= S_FETCH;
            r_wr_en   <= 1'b0;
            r_wr_src  <= 1'b0;
            r_pc_load <= 1'b0;
            r_ill     <= 1'b0;
            r_wr_sel  <= '0;
            r_rd_sel  <= '0;
            r_dst     <= '0;
            r_wr_data <= '0;
            r_lo      <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_next;
            r_wr_en   <= w_wr_en;
            r_wr_src  <= w_wr_src;
            r_pc_load <= w_pc_load;
            r_ill     <= w_ill;
            r_wr_sel  <= w_wr_sel;
            r_rd_sel  <= w_rd_sel;
            r_dst     <= w_dst;
            r_wr_data <= w_wr_data;
            r_lo      <= w_lo;
            r_addr    <= w_addr;
        end
endmodule

// File: tb/tb_opcode_decoder.sv
// tb_opcode_decoder: queue scoreboard against an instruction-level model of the 8085 decoder,
// plus directed reset, halt and ILLEGAL_HALT scenarios.
module tb_opcode_decoder;
    typedef struct {int due; int kind;} ev_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ev_t q[$];
    logic [7:0] pend[$];
    bit m_halt = 1'b0;
    logic [2:0] m_sel = '0, m_rd = '0;
    logic m_src = 1'b0;
    logic [7:0] m_data = '0;
    logic [15:0] m_addr = '0;

    always #5 clk = ~clk;

    opcode_decoder_if #(.DATA_W(8)) bus ();
    opcode_decoder_if #(.DATA_W(8)) bus1 ();
    opcode_decoder #(.DATA_W(8), .ILLEGAL_HALT(1'b0)) dut  (.clk(clk), .reset(reset), .bus(bus));
    opcode_decoder #(.DATA_W(8), .ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind);
        ev_t e;
        e.due = cyc;
        e.kind = kind;
        q.push_back(e);
    endtask

    // Instruction-level model: collect bytes until an instruction is complete, then emit its effect.
    task automatic model_accept(input logic [7:0] b);
        logic [7:0] op;
        pend.push_back(b);
        op = pend[0];
        if (pend.size() == 1) begin
            if (op == 8'h76) begin m_halt = 1'b1; pend.delete(); end
            else if (op == 8'h00) pend.delete();
            else if (op == 8'hC3) ;
            else if (op[7:6] == 2'b00 && op[2:0] == 3'd6 && op[5:3] != 3'd6) ;
            else if (op[7:6] == 2'b01 && op[5:3] != 3'd6 && op[2:0] != 3'd6) begin
                m_sel = op[5:3]; m_rd = op[2:0]; m_src = 1'b1; push(0); pend.delete();
            end else begin
                push(2); pend.delete();
            end
        end else if (op == 8'hC3) begin
            if (pend.size() == 3) begin
                m_addr = {pend[2], pend[1]}; push(1); pend.delete();
            end
        end else begin
            m_sel = op[5:3]; m_data = b; m_src = 1'b0; push(0); pend.delete();
        end
    endtask

    always @(posedge clk or negedge reset)
        if (!reset) begin
            pend.delete(); q.delete();
            m_halt = 1'b0; m_sel = '0; m_rd = '0; m_src = 1'b0; m_data = '0; m_addr = '0;
        end else begin
            cyc++;
            if (bus.instr_valid && !m_halt) model_accept(bus.instr_data);
        end

    always @(negedge clk) begin
        int k;
        if (reset) begin
            k = (q.size() != 0 && q[0].due == cyc) ? q[0].kind : -1;
            if (k >= 0) void'(q.pop_front());
            chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(k == 0));
            chk("pc_load", 32'(bus.pc_load), 32'(k == 1));
            chk("illegal_op", 32'(bus.illegal_op), 32'(k == 2));
            chk("halted", 32'(bus.halted), 32'(m_halt));
            chk("instr_ready", 32'(bus.instr_ready), 32'(!m_halt));
            chk("reg_wr_sel", 32'(bus.reg_wr_sel), 32'(m_sel));
            chk("reg_rd_sel", 32'(bus.reg_rd_sel), 32'(m_rd));
            chk("reg_wr_src", 32'(bus.reg_wr_src), 32'(m_src));
            chk("reg_wr_data", 32'(bus.reg_wr_data), 32'(m_data));
            chk("branch_address", 32'(bus.branch_address), 32'(m_addr));
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bus.instr_valid = 1'b1;
        bus.instr_data = b;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_ready"}, 32'(bus.instr_ready), 0);
        chk({n, "_wr_en"}, 32'(bus.reg_wr_en), 0);
        chk({n, "_pc_load"}, 32'(bus.pc_load), 0);
        chk({n, "_halted"}, 32'(bus.halted), 0);
        chk({n, "_wr_data"}, 32'(bus.reg_wr_data), 0);
        chk({n, "_wr_sel"}, 32'(bus.reg_wr_sel), 0);
        chk({n, "_addr"}, 32'(bus.branch_address), 0);
        chk({n, "_halted1"}, 32'(bus1.halted), 0);
        chk({n, "_ready1"}, 32'(bus1.instr_ready), 0);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bus.instr_valid = 1'b0; bus.instr_data = '0;
        bus1.instr_valid = 1'b0; bus1.instr_data = '0;
        #12 check_reset_outputs("por");
        @(posedge clk); #1 reset = 1'b1;
        // ILLEGAL_HALT=1 instance: MVI M must halt it
        bus1.instr_valid = 1'b1; bus1.instr_data = 8'h36;
        @(posedge clk); #1 bus1.instr_valid = 1'b0;
        chk("ih1_illegal", 32'(bus1.illegal_op), 1);
        chk("ih1_halted", 32'(bus1.halted), 1);
        chk("ih1_ready", 32'(bus1.instr_ready), 0);
        @(posedge clk); #1;
        chk("ih1_illegal_end", 32'(bus1.illegal_op), 0);
        chk("ih1_halted_hold", 32'(bus1.halted), 1);
        send(8'h3E, 0); send(8'h5A, 0);
        send(8'h78, 0); send(8'h00, 0);
        send(8'hC3, 2); send(8'h34, 2); send(8'h12, 0);
        send(8'h36, 0); send(8'h06, 0); send(8'h11, 1);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            do begin
                case (r)
                    0, 1, 2, 3: b = {2'b01, 6'($urandom)};
                    4, 5:       b = {2'b00, 3'($urandom), 3'd6};
                    6:          b = 8'hC3;
                    7:          b = 8'h00;
                    default:    b = 8'($urandom);
                endcase
            end while (b == 8'h76);
            send(b, $urandom_range(0, 1));
        end
        send(8'h00, 0);
        // reset mid-JMP: partial instruction must be discarded
        send(8'hC3, 0); send(8'h34, 0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk); #1 reset = 1'b1;
        send(8'h3E, 0); send(8'h01, 1);
        // HLT then a held valid: nothing further may be accepted
        send(8'h76, 0);
        bus.instr_valid = 1'b1; bus.instr_data = 8'h3E;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_outputs("hlt_rst");
        bus.instr_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        send(8'h41, 2);
        repeat (3) @(posedge clk);
        #1 chk("drain", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/opcode_decoder.md
# opcode_decoder

Parametrised 8085 instruction decoder. It consumes an instruction byte stream over a valid/ready handshake and drives register-file write controls and the program-counter load. It supports multi-byte sequencing: MVI r,d8 and JMP a16. It also handles MOV r1,r2, HLT and NOP, and flags illegal opcodes. It sits between the fetch unit and the register file/PC in the core datapath.

## Interface
- DATA_W, 8: stream/register data width; opcode is decoded from bits [7:0]; must be ≥ 8
- ILLEGAL_HALT, 0: 1 = illegal opcode enters HALT; 0 = illegal opcode is treated as NOP
- ADDR_W (localparam) = 2*DATA_W
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs clear immediately on assertion
- instr_valid  in  1  instr_data holds a valid byte
- instr_data  in  DATA_W  opcode or operand byte
- instr_ready  out  1  decoder accepts a byte when instr_valid && instr_ready
- reg_wr_en  out  1  one-cycle register-file write strobe
- reg_wr_sel  out  3  destination register code (B=0,C=1,D=2,E=3,H=4,L=5,A=7)
- reg_wr_src  out  1  0 = write reg_wr_data; 1 = write register-file read port
- reg_rd_sel  out  3  source register code for MOV
- reg_wr_data  out  DATA_W  immediate captured for MVI
- pc_load  out  1  one-cycle PC load strobe
- branch_address  out  ADDR_W  jump target {hi,lo}
- halted  out  1  decoder is in HALT
- illegal_op  out  1  one-cycle pulse on an illegal opcode accept

## Operation
- States: FETCH, IMM, ADDR_LO, ADDR_HI, HALT.
- FETCH: decode the accepted opcode.
  - 00ddd110 with ddd≠110 (MVI r): latch ddd; go to IMM.
  - 01dddsss with ddd≠110, sss≠110 (MOV): pulse reg_wr_en next cycle with reg_wr_src=1, reg_wr_sel=ddd, reg_rd_sel=sss; stay in FETCH.
  - 0xC3 (JMP): go to ADDR_LO.
  - 0x76 (HLT): go to HALT.
  - 0x00 (NOP): stay in FETCH, no strobe.
  - Any other opcode, including any M (110) operand: pulse illegal_op; go to HALT if ILLEGAL_HALT, else stay in FETCH.
- IMM: the accepted byte goes to reg_wr_data. Pulse reg_wr_en next cycle with reg_wr_src=0. Return to FETCH.
- ADDR_LO: latch the low byte; go to ADDR_HI.
- ADDR_HI: load branch_address={hi,lo} and pulse pc_load next cycle. Return to FETCH.
- HALT: instr_ready=0; halted=1. The only exit is reset.
- instr_ready is 1 in FETCH/IMM/ADDR_LO/ADDR_HI and 0 in HALT and while reset is asserted.
- A cycle with instr_valid=0 holds the current state; partial instructions wait indefinitely.
- Reset values: state FETCH; reg_wr_en, pc_load, illegal_op, halted, reg_wr_src = 0; reg_wr_sel, reg_rd_sel, reg_wr_data, branch_address = 0.
- Reset mid-instruction discards the partial instruction; the next accepted byte is decoded as an opcode.
- reg_wr_sel, reg_rd_sel, reg_wr_data and branch_address hold their last value between strobes.

## Timing
- All outputs are registered; strobes are exactly one cycle wide.
- Latency from the accept edge of the final byte to the strobe is 1 cycle, for MOV, MVI and JMP alike.
- Back-to-back instructions are allowed: a new opcode may be accepted the same cycle a strobe is high. Throughput is one byte per cycle.
- Minimum lengths:
  - MOV: 1 accept → write.
  - MVI: 2 accepts → write on cycle N+2 when bytes arrive on N, N+1.
  - JMP: 3 accepts → pc_load on N+3.
- halted rises the cycle after HLT is accepted.
- instr_ready is combinational from state only, never from instr_valid.

## Structure
- Shared package decoder_pkg:
  - opcode constants: OP_NOP=0x00, OP_HLT=0x76, OP_JMP=0xC3, MVI/MOV masks;
  - register codes REG_B..REG_A, REG_M=3'b110;
  - state enum.
- Sub-module opcode_classify: combinational opcode → {class, dst, src} lookup, reusable by the later disassembly/trace block.
- FSM and output registers live in opcode_decoder.

## Test plan
- Reset, then stream 0x3E,0x5A → reg_wr_en pulses once, 2 cycles after the first accept, with reg_wr_sel=7, reg_wr_data=0x5A, reg_wr_src=0.
- Stream 0x78 (MOV A,B) → reg_wr_en next cycle with reg_wr_sel=7, reg_rd_sel=0, reg_wr_src=1; then 0x00 → no strobe.
- Stream 0xC3,0x34,0x12 with a 2-cycle instr_valid gap between bytes → one pc_load pulse with branch_address=0x1234, one cycle after the 0x12 accept.
- Stream 0x36 (MVI M) with ILLEGAL_HALT=0 → illegal_op pulse, no reg_wr_en, next 0x06,0x11 writes B=0x11. With ILLEGAL_HALT=1 → halted=1 and instr_ready=0.
- Stream 0x76, then hold instr_valid=1 → halted=1 and no accepts; assert reset → all outputs 0 and instr_ready=1 after release.
- Stream 0xC3,0x34, then assert reset asynchronously mid-cycle → outputs clear immediately; next 0x3E,0x01 yields a write of A=0x01 and no pc_load.
